// File: rtl/aes_pkg.sv
// Shared AES definitions for the key-schedule engine.
// Holds the key-length encoding, the Nk/Nr lookup and GF(2^8) xtime.
package aes_pkg;

  typedef enum logic [1:0] {
    KEY_128  = 2'd0,
    KEY_192  = 2'd1,
    KEY_256  = 2'd2,
    KEY_RSVD = 2'd3
  } key_len_e;

  localparam int NB        = 4;
  localparam int MAX_WORDS = 60;

  typedef struct packed {
    logic [3:0] nk;
    logic [3:0] nr;
  } key_geom_t;

  // Key lengths the build cannot hold fall back to AES-128.
  function automatic key_geom_t key_geom(input key_len_e len, input int max_key_bits);
    key_geom_t g;
    g.nk = 4'd4;
    g.nr = 4'd10;
    case (len)
      KEY_192: begin
        if (max_key_bits >= 192) begin
          g.nk = 4'd6;
          g.nr = 4'd12;
        end else begin
          g.nk = 4'd4;
          g.nr = 4'd10;
        end
      end
      KEY_256: begin
        if (max_key_bits >= 256) begin
          g.nk = 4'd8;
          g.nr = 4'd14;
        end else begin
          g.nk = 4'd4;
          g.nr = 4'd10;
        end
      end
      default: begin
        g.nk = 4'd4;
        g.nr = 4'd10;
      end
    endcase
    return g;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// AES forward S-box: multiplicative inverse in GF(2^8) (x^254) followed by the affine map.
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] in_i,
  output logic [7:0] out_o
);

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) begin
        p = p ^ x;
      end else begin
        p = p;
      end
      x = xtime(x);
    end
    return p;
  endfunction

  logic [7:0] x2_s, x3_s, x6_s, x12_s, x15_s, x30_s, x60_s, x120_s, x240_s, inv_s;

  // Addition chain for x^254; zero maps to zero as required.
  always_comb begin
    x2_s   = gf_mul(in_i, in_i);
    x3_s   = gf_mul(x2_s, in_i);
    x6_s   = gf_mul(x3_s, x3_s);
    x12_s  = gf_mul(x6_s, x6_s);
    x15_s  = gf_mul(x12_s, x3_s);
    x30_s  = gf_mul(x15_s, x15_s);
    x60_s  = gf_mul(x30_s, x30_s);
    x120_s = gf_mul(x60_s, x60_s);
    x240_s = gf_mul(x120_s, x120_s);
    inv_s  = gf_mul(gf_mul(x240_s, x12_s), x2_s);
    out_o  = inv_s ^ {inv_s[6:0], inv_s[7]} ^ {inv_s[5:0], inv_s[7:6]}
           ^ {inv_s[4:0], inv_s[7:5]} ^ {inv_s[3:0], inv_s[7:4]} ^ 8'h63;
  end

endmodule

// File: rtl/aes_key_sched_seq.sv
// Sequential AES-128/192/256 key expansion: one schedule word per clock into a word buffer,
// with a registered round-key read port supporting forward and reversed round order.
module aes_key_sched_seq #(
  parameter int MAX_KEY_BITS = 256
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [1:0]   key_len_i,
  input  logic [255:0] key_i,
  input  logic         start_i,
  output logic         ready_o,
  output logic         done_o,
  output logic         key_valid_o,
  output logic [3:0]   nr_o,
  input  logic [3:0]   rd_idx_i,
  input  logic         rd_rev_i,
  output logic [127:0] rk_o
);
  import aes_pkg::*;

  localparam int NR_MAX = (MAX_KEY_BITS >= 256) ? 14 : ((MAX_KEY_BITS >= 192) ? 12 : 10);
  localparam int DEPTH  = NB * (NR_MAX + 1);

  typedef enum logic {ST_IDLE = 1'b0, ST_GEN = 1'b1} state_e;

  state_e             state_q, state_d;
  logic [3:0]         nk_q, nk_d, nr_q, nr_d;
  logic [5:0]         idx_q, idx_d;
  logic [2:0]         phase_q, phase_d;
  logic [7:0]         rcon_q, rcon_d;
  logic [7:0][31:0]   hist_q, hist_d;
  logic               done_q, done_d, valid_q, valid_d, ready_q, ready_d;
  logic [127:0]       rk_q, rk_d;
  logic [31:0]        buf_q [DEPTH];

  logic               accept_s, buf_we_s;
  key_geom_t          geom_s;
  logic [7:0][31:0]   key_w_s;
  logic [31:0]        sb_in_s, sb_out_s, temp_s, new_w_s;
  logic [3:0]         r_s;
  logic [5:0]         base_s;

  assign accept_s = start_i && ready_q;
  assign geom_s   = key_geom(key_len_e'(key_len_i), MAX_KEY_BITS);

  always_comb begin
    for (int j = 0; j < 8; j++) begin
      key_w_s[j] = key_i[255 - 32*j -: 32];
    end
  end

  // RotWord only on the Rcon step; the AES-256 mid-block step substitutes the word as is.
  always_comb begin
    if (phase_q == 3'd0) begin
      sb_in_s = {hist_q[0][23:0], hist_q[0][31:24]};
    end else begin
      sb_in_s = hist_q[0];
    end
  end

  for (genvar b = 0; b < 4; b++) begin : g_sbox
    aes_sbox u_sbox (.in_i(sb_in_s[8*b +: 8]), .out_o(sb_out_s[8*b +: 8]));
  end

  always_comb begin
    state_d  = state_q;
    nk_d     = nk_q;
    nr_d     = nr_q;
    idx_d    = idx_q;
    phase_d  = phase_q;
    rcon_d   = rcon_q;
    hist_d   = hist_q;
    done_d   = 1'b0;
    valid_d  = valid_q;
    ready_d  = ready_q;
    buf_we_s = 1'b0;
    temp_s   = hist_q[0];
    new_w_s  = 32'h0;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          nk_d    = geom_s.nk;
          nr_d    = geom_s.nr;
          idx_d   = {2'b00, geom_s.nk};
          phase_d = 3'd0;
          rcon_d  = 8'h01;
          valid_d = 1'b0;
          ready_d = 1'b0;
          state_d = ST_GEN;
          // hist[0] is the newest word, hist[Nk-1] is w[i-Nk].
          for (int j = 0; j < 8; j++) begin
            hist_d[j] = (4'(j) < geom_s.nk) ? key_w_s[3'(geom_s.nk - 4'(j) - 4'd1)] : 32'h0;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_GEN: begin
        if (phase_q == 3'd0) begin
          temp_s = sb_out_s ^ {rcon_q, 24'h0};
          rcon_d = xtime(rcon_q);
        end else if (nk_q == 4'd8 && phase_q == 3'd4) begin
          temp_s = sb_out_s;
        end else begin
          temp_s = hist_q[0];
        end
        new_w_s   = hist_q[3'(nk_q - 4'd1)] ^ temp_s;
        buf_we_s  = 1'b1;
        hist_d[0] = new_w_s;
        for (int j = 1; j < 8; j++) begin
          hist_d[j] = hist_q[j-1];
        end
        idx_d   = idx_q + 6'd1;
        phase_d = (phase_q == 3'(nk_q - 4'd1)) ? 3'd0 : phase_q + 3'd1;
        if (idx_q == {nr_q, 2'b11}) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
          valid_d = 1'b1;
          ready_d = 1'b1;
        end else begin
          state_d = ST_GEN;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Read port: four parallel word selects, zero for out-of-range or stale schedules.
  always_comb begin
    if (rd_rev_i) begin
      r_s = nr_q - rd_idx_i;
    end else begin
      r_s = rd_idx_i;
    end
    base_s = {r_s, 2'b00};
    if (valid_q && (rd_idx_i <= nr_q)) begin
      rk_d = {buf_q[base_s], buf_q[base_s + 6'd1], buf_q[base_s + 6'd2], buf_q[base_s + 6'd3]};
    end else begin
      rk_d = 128'h0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      nk_q    <= 4'd4;
      nr_q    <= 4'd0;
      idx_q   <= 6'd0;
      phase_q <= 3'd0;
      rcon_q  <= 8'h01;
      hist_q  <= '0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
      rk_q    <= 128'h0;
    end else begin
      state_q <= state_d;
      nk_q    <= nk_d;
      nr_q    <= nr_d;
      idx_q   <= idx_d;
      phase_q <= phase_d;
      rcon_q  <= rcon_d;
      hist_q  <= hist_d;
      done_q  <= done_d;
      valid_q <= valid_d;
      ready_q <= ready_d;
      rk_q    <= rk_d;
    end
  end

  // Schedule storage; contents are meaningless until key_valid_o is set.
  always_ff @(posedge clk) begin
    for (int j = 0; j < 8; j++) begin
      if (!rst && accept_s && (4'(j) < geom_s.nk)) begin
        buf_q[j] <= key_w_s[j];
      end
    end
    if (!rst && buf_we_s) begin
      buf_q[idx_q] <= new_w_s;
    end
  end

  assign ready_o     = ready_q;
  assign done_o      = done_q;
  assign key_valid_o = valid_q;
  assign nr_o        = nr_q;
  assign rk_o        = rk_q;

endmodule

// File: tb/tb_aes_key_sched_seq.sv
// Directed self-checking bench for aes_key_sched_seq using FIPS-197 key-expansion vectors.
module tb_aes_key_sched_seq;

  logic         clk = 1'b0;
  logic         rst;
  logic [1:0]   key_len_i;
  logic [255:0] key_i;
  logic         start_i;
  logic         ready_o, done_o, key_valid_o;
  logic [3:0]   nr_o;
  logic [3:0]   rd_idx_i;
  logic         rd_rev_i;
  logic [127:0] rk_o;

  int total = 0;
  int bad   = 0;
  logic [127:0] exp_q[$];

  localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [255:0] K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
  localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
  localparam logic [127:0] R128_0  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] R128_1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] R128_10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] R192_0  = 128'h8e73b0f7da0e6452c810f32b809079e5;
  localparam logic [127:0] R192_12 = 128'he98ba06f448c773c8ecc720401002202;
  localparam logic [127:0] R256_1  = 128'h1f352c073b6108d72d9810a30914dff4;
  localparam logic [127:0] R256_14 = 128'hfe4890d1e6188d0b046df344706c631e;

  always #5 clk = ~clk;

  aes_key_sched_seq #(.MAX_KEY_BITS(256)) dut (
    .clk(clk), .rst(rst), .key_len_i(key_len_i), .key_i(key_i), .start_i(start_i),
    .ready_o(ready_o), .done_o(done_o), .key_valid_o(key_valid_o), .nr_o(nr_o),
    .rd_idx_i(rd_idx_i), .rd_rev_i(rd_rev_i), .rk_o(rk_o)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic rd(input logic [3:0] idx, input logic rev, input logic [127:0] expv, input string tag);
    rd_idx_i = idx;
    rd_rev_i = rev;
    exp_q.push_back(expv);
    @(posedge clk); #1;
    chk(tag, rk_o, exp_q.pop_front());
  endtask

  task automatic start(input logic [1:0] len, input logic [255:0] key);
    key_len_i = len;
    key_i     = key;
    start_i   = 1'b1;
    @(posedge clk); #1;
    start_i   = 1'b0;
  endtask

  task automatic wait_done(input int exp_n, input string tag);
    int n = 0;
    while (n < 200 && !done_o) begin
      @(posedge clk); #1;
      n++;
    end
    chk(tag, 128'(n), 128'(exp_n));
  endtask

  initial begin
    rst = 1'b1; start_i = 1'b0; key_len_i = 2'd0; key_i = 256'h0;
    rd_idx_i = 4'd0; rd_rev_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 128'(ready_o), 128'd1);
    chk("rst_done", 128'(done_o), 128'd0);
    chk("rst_valid", 128'(key_valid_o), 128'd0);
    chk("rst_nr", 128'(nr_o), 128'd0);
    chk("rst_rk", rk_o, 128'h0);
    rst = 1'b0;

    start(2'd0, K128);
    chk("gen_ready_low", 128'(ready_o), 128'd0);
    wait_done(40, "done128_lat");
    chk("done128_valid", 128'(key_valid_o), 128'd1);
    chk("done128_ready", 128'(ready_o), 128'd1);
    chk("nr128", 128'(nr_o), 128'd10);
    rd(4'd1, 1'b0, R128_1, "k128_r1");
    rd(4'd10, 1'b0, R128_10, "k128_r10");
    rd(4'd0, 1'b1, R128_10, "k128_rev0");
    rd(4'd10, 1'b1, R128_0, "k128_rev10");
    rd(4'd0, 1'b0, R128_0, "k128_r0");
    rd(4'd11, 1'b0, 128'h0, "k128_idx11");

    // Restart over a valid schedule with the reserved length code.
    rd_idx_i = 4'd1; rd_rev_i = 1'b0;
    start(2'd3, K128);
    chk("restart_valid_low", 128'(key_valid_o), 128'd0);
    rd(4'd1, 1'b0, 128'h0, "restart_rk_zero");
    rd(4'd0, 1'b0, 128'h0, "restart_rk_zero2");
    wait_done(38, "restart_lat");
    chk("rsvd_nr", 128'(nr_o), 128'd10);
    rd(4'd10, 1'b0, R128_10, "rsvd_r10");

    start(2'd1, K192);
    wait_done(46, "done192_lat");
    chk("nr192", 128'(nr_o), 128'd12);
    rd(4'd12, 1'b0, R192_12, "k192_r12");
    rd(4'd0, 1'b0, R192_0, "k192_r0");
    rd(4'd0, 1'b1, R192_12, "k192_rev0");
    rd(4'd13, 1'b0, 128'h0, "k192_idx13");

    // Back-to-back: second start lands on the done cycle.
    start(2'd0, K128);
    wait_done(40, "b2b_first_lat");
    start(2'd2, K256);
    wait_done(52, "b2b_256_lat");
    chk("nr256", 128'(nr_o), 128'd14);
    rd(4'd14, 1'b0, R256_14, "k256_r14");
    rd(4'd1, 1'b0, R256_1, "k256_r1");
    rd(4'd0, 1'b1, R256_14, "k256_rev0");

    // Start pulsed during GEN must be ignored.
    start(2'd0, K128);
    key_len_i = 2'd2; key_i = K256; start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    wait_done(39, "ignored_start_lat");
    chk("ignored_nr", 128'(nr_o), 128'd10);
    rd(4'd1, 1'b0, R128_1, "ignored_r1");

    // Reset in the middle of generation.
    start(2'd1, K192);
    repeat (20) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_ready", 128'(ready_o), 128'd1);
    chk("midrst_valid", 128'(key_valid_o), 128'd0);
    chk("midrst_rk", rk_o, 128'h0);
    chk("midrst_nr", 128'(nr_o), 128'd0);
    chk("midrst_done", 128'(done_o), 128'd0);
    start(2'd2, K256);
    wait_done(52, "postrst_lat");
    rd(4'd14, 1'b0, R256_14, "postrst_r14");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
